pipe_ctrl: RTL



---
 rtl/pipe_pkg.sv | 21 ++
 rtl/pipe_ctrl_stall_wdog.sv | 50 +++++
 rtl/pipe_ctrl.sv | 136 +++++++++++++
 3 files changed

// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline control unit.
//   pipe_state_e : control FSM states
//   STG_*        : stage-register indices into the stall/bubble/flush vectors
//   NOP_INSTR    : instruction the stage registers load on bubble or flush
package pipe_pkg;

    typedef enum logic {
        RUN   = 1'b0,
        FLUSH = 1'b1
    } pipe_state_e;

    localparam int STG_PC     = 0;
    localparam int STG_IFID   = 1;
    localparam int STG_IDEXE  = 2;
    localparam int STG_EXEMEM = 3;
    localparam int STG_MEMWB  = 4;

    // sll $0, $0, 0 -- the canonical MIPS NOP
    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

endpackage

// File: rtl/pipe_ctrl_stall_wdog.sv
// Stall watchdog: saturating count of consecutive stalled cycles with a
// sticky error flag once the count reaches MAX_STALL.
// Ports:
//   clk, reset  : core clock, synchronous active-high reset
//   stall_run   : PC is frozen this cycle while the pipeline is running
//   stall_cnt   : current consecutive-stall count
//   wdog_err    : sticky trip flag, cleared only by reset
module stall_wdog #(
    parameter int WDOG_W    = 8,
    parameter int MAX_STALL = 200
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              stall_run,
    output logic [WDOG_W-1:0] stall_cnt,
    output logic              wdog_err
);

    logic [WDOG_W-1:0] stall_cnt_q, stall_cnt_d;
    logic              wdog_err_q, wdog_err_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        wdog_err_d  = wdog_err_q;
        if (!stall_run) begin
            stall_cnt_d = '0;
        end else if (stall_cnt_q != '1) begin
            stall_cnt_d = stall_cnt_q + WDOG_W'(1);
        end
        // The count must pass through MAX_STALL on its way to saturation,
        // so an equality compare is enough to catch the trip.
        if (stall_cnt_q == WDOG_W'(MAX_STALL)) begin
            wdog_err_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt_q <= '0;
            wdog_err_q  <= 1'b0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            wdog_err_q  <= wdog_err_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign wdog_err  = wdog_err_q;

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline control unit: turns per-stage stall requests into the stall and
// bubble vectors, runs the flush/redirect sequence, and hosts the watchdog.
//
//   state | meaning
//   ------+-----------------------------------------------------------
//   RUN   | normal operation, stall/bubble follow stall_req
//   FLUSH | pipeline registers cleared, stall_req ignored
//
// Ports:
//   clk, reset      : core clock, synchronous active-high reset
//   stall_req       : bit i = stage i cannot advance this cycle
//   flush_req       : single-cycle flush/redirect request
//   flush_pc        : redirect target, sampled with flush_req
//   stall           : freeze enable per stage register
//   bubble          : load NOP into stage register i
//   flush           : clear stage register i (bit 0 always 0)
//   redirect_valid  : one-cycle pulse, PC loads redirect_pc
//   redirect_pc     : registered redirect target
//   busy            : high while in FLUSH
//   stall_cnt       : consecutive-stall count
//   wdog_err        : sticky watchdog trip
module pipe_ctrl #(
    parameter int STAGES       = 6,
    parameter int ADDR_W       = 32,
    parameter int FLUSH_CYCLES = 1,
    parameter int WDOG_W       = 8,
    parameter int MAX_STALL    = 200
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [STAGES-1:0] stall_req,
    input  logic              flush_req,
    input  logic [ADDR_W-1:0] flush_pc,
    output logic [STAGES-1:0] stall,
    output logic [STAGES-1:0] bubble,
    output logic [STAGES-1:0] flush,
    output logic              redirect_valid,
    output logic [ADDR_W-1:0] redirect_pc,
    output logic              busy,
    output logic [WDOG_W-1:0] stall_cnt,
    output logic              wdog_err
);
    import pipe_pkg::*;

    localparam int CNT_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
    localparam logic [CNT_W-1:0] FLUSH_LOAD = CNT_W'(FLUSH_CYCLES - 1);

    pipe_state_e       state_q, state_d;
    logic [CNT_W-1:0]  fcnt_q, fcnt_d;
    logic              redirect_valid_q, redirect_valid_d;
    logic [ADDR_W-1:0] redirect_pc_q, redirect_pc_d;

    logic [STAGES-1:0] stall_run;
    logic [STAGES-1:0] bubble_run;
    logic              stall_any;
    logic              in_flush;

    assign in_flush = (state_q == FLUSH);

    // A request at stage j freezes j and everything upstream of it; the
    // bubble goes into the first register below the frozen region.
    always_comb begin
        stall_any  = 1'b0;
        stall_run  = '0;
        bubble_run = '0;
        for (int i = STAGES - 1; i >= 0; i--) begin
            stall_any    = stall_any | stall_req[i];
            stall_run[i] = stall_any;
        end
        for (int i = 1; i < STAGES; i++) begin
            bubble_run[i] = stall_run[i-1] & ~stall_run[i];
        end
    end

    always_comb begin
        state_d          = state_q;
        fcnt_d           = fcnt_q;
        redirect_valid_d = 1'b0;
        redirect_pc_d    = redirect_pc_q;
        stall            = '0;
        bubble           = '0;
        flush            = '0;
        case (state_q)
            RUN: begin
                stall  = stall_run;
                bubble = bubble_run;
            end
            FLUSH: begin
                flush = {{(STAGES-1){1'b1}}, 1'b0};
                if (fcnt_q == '0) begin
                    state_d = RUN;
                end else begin
                    fcnt_d = fcnt_q - CNT_W'(1);
                end
            end
            default: state_d = RUN;
        endcase
        // A new request wins in either state and restarts the sequence.
        if (flush_req) begin
            state_d          = FLUSH;
            fcnt_d           = FLUSH_LOAD;
            redirect_valid_d = 1'b1;
            redirect_pc_d    = flush_pc;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q          <= RUN;
            fcnt_q           <= '0;
            redirect_valid_q <= 1'b0;
            redirect_pc_q    <= '0;
        end else begin
            state_q          <= state_d;
            fcnt_q           <= fcnt_d;
            redirect_valid_q <= redirect_valid_d;
            redirect_pc_q    <= redirect_pc_d;
        end
    end

    assign redirect_valid = redirect_valid_q;
    assign redirect_pc    = redirect_pc_q;
    assign busy           = in_flush;

    stall_wdog #(
        .WDOG_W    (WDOG_W),
        .MAX_STALL (MAX_STALL)
    ) u_stall_wdog (
        .clk       (clk),
        .reset     (reset),
        .stall_run (~in_flush & stall_run[0]),
        .stall_cnt (stall_cnt),
        .wdog_err  (wdog_err)
    );

endmodule
